// File: rtl/request_queue_conditioner.sv
// ============================================================================
//  Module   : request_queue_conditioner
//  Purpose  : Synchronises and debounces four push buttons, queues one request
//             per press and retires one request whenever a line's grant ends.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module request_queue_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           btn_in,
    input  logic [3:0]           grant_in,
    output logic [3:0]           request_queue,
    output logic [4*CNT_W-1:0]   pending_count,
    output logic [3:0]           overflow
);

    localparam int                DCNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] grant_dly_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            grant_dly_q <= '0;
        end else begin
            sync1_q     <= btn_in;
            sync2_q     <= sync1_q;
            grant_dly_q <= grant_in;
        end
    end

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_line
            logic [DCNT_W-1:0] dcnt_q, dcnt_d;
            logic              db_q, db_d;
            logic              db_dly_q;
            logic              press_q;
            logic              retire;
            logic [CNT_W-1:0]  cnt_q, cnt_d;
            logic              ovf_q, ovf_d;
            logic              rq_q, rq_d;

            always_comb begin
                dcnt_d = '0;
                db_d   = db_q;
                if (sync2_q[i] != db_q) begin
                    if (dcnt_q == DCNT_LAST) begin
                        db_d = sync2_q[i];
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end
            end

            // A grant that just dropped marks the end of this line's slice.
            always_comb begin
                retire = grant_dly_q[i] & ~grant_in[i];
                cnt_d  = cnt_q;
                ovf_d  = ovf_q;
                if (press_q && !retire) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (retire && !press_q && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                rq_d = (cnt_d != '0);
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    dcnt_q   <= '0;
                    db_q     <= 1'b0;
                    db_dly_q <= 1'b0;
                    press_q  <= 1'b0;
                    cnt_q    <= '0;
                    ovf_q    <= 1'b0;
                    rq_q     <= 1'b0;
                end else begin
                    dcnt_q   <= dcnt_d;
                    db_q     <= db_d;
                    db_dly_q <= db_q;
                    press_q  <= db_q & ~db_dly_q;
                    cnt_q    <= cnt_d;
                    ovf_q    <= ovf_d;
                    rq_q     <= rq_d;
                end
            end

            assign pending_count[i*CNT_W +: CNT_W] = cnt_q;
            assign request_queue[i]                = rq_q;
            assign overflow[i]                     = ovf_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_request_queue_conditioner.sv
// ============================================================================
//  Module   : tb_request_queue_conditioner
//  Purpose  : Scenario tasks plus randomized traffic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_request_queue_conditioner;

    localparam int D    = 4;
    localparam int CW   = 3;
    localparam int MAXC = 7;

    logic        clk;
    logic        reset;
    logic [3:0]  btn_in;
    logic [3:0]  grant_in;
    logic [3:0]  request_queue;
    logic [11:0] pending_count;
    logic [3:0]  overflow;
    logic [19:0] dut_vec;

    int checks;
    int passes;

    request_queue_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_in        (btn_in),
        .grant_in      (grant_in),
        .request_queue (request_queue),
        .pending_count (pending_count),
        .overflow      (overflow)
    );

    assign dut_vec = {request_queue, pending_count, overflow};

    always #5 clk = ~clk;

    // Behavioural reference: button history, run length of disagreement,
    // press delivery countdown and a saturating request counter per line.
    bit m_b1[4], m_b2[4], m_db[4], m_ovf[4], m_gprev[4];
    int m_run[4], m_cd[4], m_cnt[4];

    task automatic model_update();
        bit sv, pr, rt;
        for (int l = 0; l < 4; l++) begin
            if (reset) begin
                m_b1[l] = 0; m_b2[l] = 0; m_db[l] = 0; m_ovf[l] = 0; m_gprev[l] = 0;
                m_run[l] = 0; m_cd[l] = 0; m_cnt[l] = 0;
            end else begin
                sv = m_b2[l];
                m_b2[l] = m_b1[l];
                m_b1[l] = btn_in[l];
                pr = 0;
                if (m_cd[l] > 0) begin
                    m_cd[l]--;
                    pr = (m_cd[l] == 0);
                end
                if (sv != m_db[l]) begin
                    m_run[l]++;
                    if (m_run[l] == D) begin
                        m_db[l] = sv;
                        m_run[l] = 0;
                        if (sv) m_cd[l] = 2;
                    end
                end else begin
                    m_run[l] = 0;
                end
                rt = m_gprev[l] && !grant_in[l];
                if (pr && !rt) begin
                    if (m_cnt[l] < MAXC) m_cnt[l]++;
                    else m_ovf[l] = 1;
                end else if (rt && !pr && m_cnt[l] > 0) begin
                    m_cnt[l]--;
                end
                m_gprev[l] = grant_in[l];
            end
        end
    endtask

    function automatic logic [19:0] model_vec();
        logic [3:0]  rq, ov;
        logic [11:0] pc;
        for (int l = 0; l < 4; l++) begin
            rq[l] = (m_cnt[l] != 0);
            ov[l] = m_ovf[l];
            pc[l*CW +: CW] = CW'(m_cnt[l]);
        end
        return {rq, pc, ov};
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic press(input logic [3:0] mask);
        btn_in = btn_in | mask;
        idle(8);
        btn_in = btn_in & ~mask;
        idle(8);
    endtask

    task automatic do_reset();
        reset = 1; btn_in = '0; grant_in = '0;
        step(); step();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; btn_in = 4'hF; grant_in = 4'hF;
        step();
        checks++;
        if (dut_vec !== 20'h0) $display("FAIL reset_first_edge: got %h expected %h", dut_vec, 20'h0);
        else passes++;
        step();
        reset = 0;
        for (int e = 0; e < 7; e++) begin
            step();
            checks++;
            if (request_queue !== 4'h0) $display("FAIL no_early_req edge %0d: got %b expected 0000", e, request_queue);
            else passes++;
        end
        step();
        checks++;
        if (request_queue !== 4'hF) $display("FAIL req_after_release: got %b expected 1111", request_queue);
        else passes++;
        btn_in = '0; grant_in = '0;
        step();
        checks++;
        if (dut_vec !== model_vec()) $display("FAIL reset_retire_all: got %h expected %h", dut_vec, model_vec());
        else passes++;
    endtask

    task automatic test_clean_press();
        do_reset();
        btn_in[0] = 1'b1;
        for (int e = 0; e < 7; e++) step();
        checks++;
        if (request_queue !== 4'b0000) $display("FAIL press_latency_early: got %b expected 0000", request_queue);
        else passes++;
        step();
        checks++;
        if ({request_queue, pending_count[2:0]} !== {4'b0001, 3'd1}) $display("FAIL press_latency: got %b/%0d expected 0001/1", request_queue, pending_count[2:0]);
        else passes++;
        btn_in[0] = 1'b0;
        idle(10);
        press(4'b0001);
        checks++;
        if (pending_count[2:0] !== 3'd2) $display("FAIL second_press: got %0d expected 2", pending_count[2:0]);
        else passes++;
    endtask

    task automatic test_bounce();
        int rose;
        do_reset();
        rose = 0;
        for (int c = 0; c < 40; c++) begin
            btn_in[1] = c[1];
            step();
            if (request_queue[1]) rose = 1;
        end
        btn_in[1] = 1'b0;
        idle(12);
        checks++;
        if ({rose[0], pending_count[5:3]} !== 4'b0) $display("FAIL bounce_reject: got rose=%0d count=%0d expected 0/0", rose, pending_count[5:3]);
        else passes++;
    endtask

    task automatic test_grant_retire();
        do_reset();
        press(4'b0100); press(4'b0100);
        for (int r = 0; r < 2; r++) begin
            grant_in[2] = 1'b1;
            idle(10);
            grant_in[2] = 1'b0;
            step();
            checks++;
            if ({request_queue[2], pending_count[8:6]} !== {(r == 0), 3'(1 - r)})
                $display("FAIL grant_retire %0d: got rq=%b count=%0d expected rq=%b count=%0d",
                         r, request_queue[2], pending_count[8:6], (r == 0), 1 - r);
            else passes++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int p = 0; p < 7; p++) press(4'b1000);
        checks++;
        if ({pending_count[11:9], overflow[3]} !== {3'd7, 1'b0}) $display("FAIL sat_seven: got %0d/%b expected 7/0", pending_count[11:9], overflow[3]);
        else passes++;
        press(4'b1000);
        checks++;
        if ({pending_count[11:9], overflow[3]} !== {3'd7, 1'b1}) $display("FAIL sat_overflow: got %0d/%b expected 7/1", pending_count[11:9], overflow[3]);
        else passes++;
    endtask

    task automatic test_press_retire();
        do_reset();
        for (int p = 0; p < 3; p++) press(4'b0001);
        btn_in[0] = 1'b1; grant_in[0] = 1'b1;
        idle(7);
        grant_in[0] = 1'b0;
        step();
        checks++;
        if ({pending_count[2:0], overflow[0]} !== {3'd3, 1'b0}) $display("FAIL press_retire_same: got %0d/%b expected 3/0", pending_count[2:0], overflow[0]);
        else passes++;
        btn_in[0] = 1'b0;
        idle(8);
        checks++;
        if (dut_vec !== model_vec()) $display("FAIL press_retire_model: got %h expected %h", dut_vec, model_vec());
        else passes++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int p = 0; p < 8; p++) press({1'b1, (p < 2), (p < 1), 1'b0});
        checks++;
        if ({pending_count, overflow} !== {3'd7, 3'd2, 3'd1, 3'd0, 4'b1000}) $display("FAIL mid_setup: got %h/%b expected counts 7,2,1,0 ovf 1000", pending_count, overflow);
        else passes++;
        btn_in[1] = 1'b1;
        idle(4);
        reset = 1; btn_in = '0;
        step();
        reset = 0;
        checks++;
        if (dut_vec !== 20'h0) $display("FAIL mid_reset_clear: got %h expected %h", dut_vec, 20'h0);
        else passes++;
        idle(12);
        checks++;
        if (dut_vec !== 20'h0) $display("FAIL mid_reset_no_press: got %h expected %h", dut_vec, 20'h0);
        else passes++;
    endtask

    task automatic test_random();
        int bhold[4];
        int ghold;
        do_reset();
        for (int l = 0; l < 4; l++) bhold[l] = 1;
        ghold = 1;
        for (int c = 0; c < 1500; c++) begin
            for (int l = 0; l < 4; l++) begin
                bhold[l]--;
                if (bhold[l] == 0) begin
                    btn_in[l] = ~btn_in[l];
                    bhold[l] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(6, 14);
                end
            end
            ghold--;
            if (ghold == 0) begin
                grant_in = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'(1 << $urandom_range(0, 3));
                ghold = $urandom_range(1, 6);
            end
            step();
            checks++;
            if (dut_vec !== model_vec()) $display("FAIL random cyc %0d: got %h expected %h", c, dut_vec, model_vec());
            else passes++;
        end
    endtask

    initial begin
        clk = 0; reset = 1; btn_in = '0; grant_in = '0;
        checks = 0; passes = 0;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_grant_retire();
        test_saturation();
        test_press_retire();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
